// File: rtl/score_table_ctrl.sv
// Score-table controller: read-modify-write updates per player ID against a
// single-port synchronous RAM, plus a valid/ready dump of the whole table.
module score_table_ctrl #(
    parameter int ID_W    = 16,
    parameter int SCORE_W = 16,
    parameter int DEPTH   = 256,
    parameter int RAM_LAT = 2,
    parameter int MODE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [ID_W-1:0]    cmd_id,
    input  logic [SCORE_W-1:0] cmd_score,
    output logic               cmd_err,
    output logic [ID_W-1:0]    ram_addr,
    output logic               ram_wren,
    output logic [SCORE_W-1:0] ram_wdata,
    input  logic [SCORE_W-1:0] ram_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [SCORE_W-1:0] out_score,
    output logic               out_last,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, UPD_RD, UPD_WR, DMP_RD, DMP_OUT} state_t;

    localparam logic [2:0]      LAT_CNT   = 3'(RAM_LAT);
    localparam logic [ID_W:0]   DEPTH_EXT = (ID_W+1)'(DEPTH);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(DEPTH-1);

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [ID_W-1:0]    idx_reg, idx_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [ID_W-1:0]    ram_addr_reg, ram_addr_next;
    logic               ram_wren_reg, ram_wren_next;
    logic [SCORE_W-1:0] ram_wdata_reg, ram_wdata_next;
    logic               out_valid_reg, out_valid_next;
    logic [ID_W-1:0]    out_id_reg, out_id_next;
    logic [SCORE_W-1:0] out_score_reg, out_score_next;
    logic               out_last_reg, out_last_next;
    logic               cmd_err_reg, cmd_err_next;

    logic [SCORE_W:0]   sum_ext;
    logic [SCORE_W-1:0] new_score;

    // Update policy applied to the value just read back from the RAM.
    always_comb begin
        sum_ext = {1'b0, ram_rdata} + {1'b0, score_reg};
        case (MODE)
            1:       new_score = sum_ext[SCORE_W] ? '1 : sum_ext[SCORE_W-1:0];
            2:       new_score = (ram_rdata > score_reg) ? ram_rdata : score_reg;
            default: new_score = score_reg;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        score_next     = score_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wren_next  = 1'b0;
        ram_wdata_next = ram_wdata_reg;
        out_valid_next = out_valid_reg;
        out_id_next    = out_id_reg;
        out_score_next = out_score_reg;
        out_last_next  = out_last_reg;
        cmd_err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op) begin
                        idx_next      = '0;
                        ram_addr_next = '0;
                        cnt_next      = '0;
                        state_next    = DMP_RD;
                    end else if ({1'b0, cmd_id} >= DEPTH_EXT) begin
                        cmd_err_next = 1'b1;
                    end else begin
                        ram_addr_next = cmd_id;
                        score_next    = cmd_score;
                        cnt_next      = '0;
                        state_next    = UPD_RD;
                    end
                end
            end
            UPD_RD: begin
                if (cnt_reg == LAT_CNT) begin
                    ram_wren_next  = 1'b1;
                    ram_wdata_next = new_score;
                    state_next     = UPD_WR;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            UPD_WR: state_next = IDLE;
            DMP_RD: begin
                if (cnt_reg == LAT_CNT) begin
                    out_valid_next = 1'b1;
                    out_id_next    = idx_reg;
                    out_score_next = ram_rdata;
                    out_last_next  = (idx_reg == LAST_IDX);
                    state_next     = DMP_OUT;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            DMP_OUT: begin
                // Entry held stable until the sink takes it.
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (out_last_reg) begin
                        out_last_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        idx_next      = idx_reg + ID_W'(1);
                        ram_addr_next = idx_reg + ID_W'(1);
                        cnt_next      = '0;
                        state_next    = DMP_RD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            score_reg     <= '0;
            ram_addr_reg  <= '0;
            ram_wren_reg  <= 1'b0;
            ram_wdata_reg <= '0;
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_score_reg <= '0;
            out_last_reg  <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            score_reg     <= score_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wren_reg  <= ram_wren_next;
            ram_wdata_reg <= ram_wdata_next;
            out_valid_reg <= out_valid_next;
            out_id_reg    <= out_id_next;
            out_score_reg <= out_score_next;
            out_last_reg  <= out_last_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = ~cmd_ready;
    assign cmd_err   = cmd_err_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wren  = ram_wren_reg;
    assign ram_wdata = ram_wdata_reg;
    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_score = out_score_reg;
    assign out_last  = out_last_reg;
endmodule

// File: doc/score_table_ctrl.md
# score_table_ctrl

Parametrised score-table controller between the game FSM and a single-port synchronous score RAM. It performs read-modify-write score updates per player ID, with a selectable overwrite, saturating-accumulate or keep-max policy. On request it streams the whole table out over a valid/ready interface to the scoreboard display path. RAM read latency, ID/score widths and table depth are configurable.

## Interface
- ID_W, 16, player ID / RAM address width
- SCORE_W, 16, score / RAM data width
- DEPTH, 256, table entries scanned by a dump; legal range 1..2^ID_W
- RAM_LAT, 2, RAM read latency in cycles; legal range 1..7
- MODE, 0, update policy: 0 overwrite, 1 saturating accumulate, 2 keep max (unsigned)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle and accepting a command
- cmd_op  in  1  0 = update, 1 = dump
- cmd_id  in  ID_W  player ID (update only)
- cmd_score  in  SCORE_W  score operand (update only)
- cmd_err  out  1  one-cycle pulse: update rejected because cmd_id >= DEPTH
- ram_addr  out  ID_W  RAM address, registered
- ram_wren  out  1  RAM write enable, registered
- ram_wdata  out  SCORE_W  RAM write data, registered
- ram_rdata  in  SCORE_W  RAM read data, valid RAM_LAT cycles after ram_addr
- out_valid  out  1  dump entry valid
- out_ready  in  1  dump sink accepts entry
- out_id  out  ID_W  dump entry address
- out_score  out  SCORE_W  dump entry score
- out_last  out  1  high with the entry at DEPTH-1
- busy  out  1  equals ~cmd_ready

## Operation
- States: IDLE, UPD_RD, UPD_WR, DMP_RD, DMP_OUT. A wait counter of width 3 counts RAM_LAT.
- cmd_ready = (state == IDLE). Commands are accepted only on cmd_valid & cmd_ready. While busy, cmd_valid is ignored and the requester holds its command.
- Reset (rst low, at any time, including mid-operation): state IDLE, and all registered outputs are 0. This covers ram_addr, ram_wren, ram_wdata, out_valid, out_id, out_score, out_last and cmd_err. No partial write is issued after reset, and a dump in progress is abandoned.
- Update with cmd_id >= DEPTH: cmd_err pulses for one cycle, there is no RAM access, and the controller stays in IDLE.
- Update with a valid ID: latch id/score, then UPD_RD drives ram_addr=id with wren=0. After RAM_LAT cycles the controller samples ram_rdata as old. It computes new, then UPD_WR issues one cycle of wren=1, wdata=new, and the controller returns to IDLE.
  - MODE 0: new = score. The read is still performed, so latency is uniform.
  - MODE 1: new = old + score. On carry-out, new = all-ones.
  - MODE 2: new = max(old, score), unsigned.
- Dump: address index starts at 0. DMP_RD drives ram_addr=index and waits RAM_LAT. DMP_OUT registers out_id=index, out_score=ram_rdata, out_valid=1 and out_last=(index==DEPTH-1).
  - The outputs hold stable until out_valid & out_ready.
  - On that handshake: if last, out_valid drops and the controller returns to IDLE; otherwise index+1 and the controller returns to DMP_RD.
- ram_wren is 1 only in the single UPD_WR cycle. The dump never writes.

## Timing
- Update accepted at edge E0: ram_addr = id from E0. ram_rdata is sampled at edge E0+RAM_LAT+1, and wren=1 during the cycle after it. The controller is back in IDLE (cmd_ready=1) after edge E0+RAM_LAT+2. Total busy time is RAM_LAT+2 cycles.
- Dump accepted at E0: the first out_valid rises after edge E0+RAM_LAT+1. Each later entry appears RAM_LAT+1 cycles after the previous handshake. Minimum dump duration is DEPTH·(RAM_LAT+2) cycles with out_ready tied high.
- Back-to-back: a command presented in the cycle cmd_ready returns is accepted on that edge.
- cmd_err is registered and appears the cycle after acceptance.

## Test plan
- Reset: assert rst low mid-dump at entry 5 -> all outputs 0 and cmd_ready=1 immediately. After release, no RAM write occurs.
- MODE 1, RAM_LAT=2: old=0xFFF0, update id=3 with 0x0020 -> exactly one write to addr 3 with data 0xFFFF. cmd_ready is low for 4 cycles.
- MODE 2: old=100 at id 7, update with 50 then 200 -> writes 100, then 200.
- Dump with DEPTH=4 and RAM preloaded {10,20,30,40}, out_ready low for 3 cycles on entry 1 -> the stream is (0,10),(1,20),(2,30),(3,40), outputs stay stable while stalled, and out_last is set on id 3 only.
- Update with cmd_id=DEPTH -> cmd_err is a single-cycle pulse, ram_wren stays 0, and cmd_ready stays 1.
- cmd_valid held during an update with new cmd_id/cmd_score changing -> those changes are ignored until cmd_ready returns, and the RAM is written with the originally latched values.
